// File: rtl/hp_reg3_sync.sv
// Host-to-parasite register 3: two-byte FIFO for 16-bit block transfers.
// In one-byte mode it acts as a single latch; in two-byte mode the flags track complete groups.
module hp_reg3_sync #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] RST_BYTE0 = 8'hAA,
  parameter logic [DATA_W-1:0] RST_BYTE1 = 8'hEE
) (
  input  logic              h_phi2,
  input  logic              h_rst,
  input  logic              h_wr_stb,
  input  logic [DATA_W-1:0] h_data,
  input  logic              p_rd_stb,
  input  logic              one_byte_mode,
  output logic [DATA_W-1:0] p_data,
  output logic              p_data_available,
  output logic              p_zero_bytes_available,
  output logic              h_full,
  output logic              h_overrun,
  output logic              p_underrun
);

  logic [DATA_W-1:0] byte0_q, byte0_d;
  logic [DATA_W-1:0] byte1_q, byte1_d;
  logic              v0_q, v0_d;
  logic              v1_q, v1_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;
  logic              wr_ok;

  // Flags are pure decodes of the valid bits under the current mode.
  assign h_full                 = one_byte_mode ? v0_q : v1_q;
  assign p_data_available       = (v0_q & one_byte_mode) | v1_q;
  assign p_zero_bytes_available = ~(v0_q | (v1_q & ~one_byte_mode));
  assign p_data                 = v0_q ? byte0_q : byte1_q;
  assign h_overrun              = overrun_q;
  assign p_underrun             = underrun_q;

  assign wr_ok = h_wr_stb & ~h_full;

  // Read and write are both judged on pre-edge state; the bits they touch never collide.
  always_comb begin
    byte0_d    = byte0_q;
    byte1_d    = byte1_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    overrun_d  = h_wr_stb & h_full;
    underrun_d = 1'b0;

    if (p_rd_stb) begin
      if (v0_q) begin
        v0_d = 1'b0;
      end else if (!one_byte_mode && v1_q) begin
        v1_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end

    // In two-byte mode an accepted write implies !v1, so !v0 selects the first slot.
    if (wr_ok) begin
      if (one_byte_mode || !v0_q) begin
        byte0_d = h_data;
        v0_d    = 1'b1;
      end else begin
        byte1_d = h_data;
        v1_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge h_phi2 or posedge h_rst) begin
    if (h_rst) begin
      byte0_q    <= RST_BYTE0;
      byte1_q    <= RST_BYTE1;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      byte0_q    <= byte0_d;
      byte1_q    <= byte1_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_hp_reg3_sync.sv
// Directed and random checks of hp_reg3_sync against a two-slot reference model and byte queue.
// Strobes are driven 1ns after a rising edge and outputs are sampled 1ns after the next one.
module tb_hp_reg3_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       h_wr_stb;
  logic [7:0] h_data;
  logic       p_rd_stb;
  logic       one_byte_mode;
  logic [7:0] p_data;
  logic       p_data_available;
  logic       p_zero_bytes_available;
  logic       h_full;
  logic       h_overrun;
  logic       p_underrun;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  // reference model state
  logic       m_v0, m_v1, m_ovr, m_und;
  logic [7:0] m_b0, m_b1;

  always #5 clk = ~clk;

  hp_reg3_sync #(.DATA_W(8), .RST_BYTE0(8'hAA), .RST_BYTE1(8'hEE)) dut (
    .h_phi2                 (clk),
    .h_rst                  (rst),
    .h_wr_stb               (h_wr_stb),
    .h_data                 (h_data),
    .p_rd_stb               (p_rd_stb),
    .one_byte_mode          (one_byte_mode),
    .p_data                 (p_data),
    .p_data_available       (p_data_available),
    .p_zero_bytes_available (p_zero_bytes_available),
    .h_full                 (h_full),
    .h_overrun              (h_overrun),
    .p_underrun             (p_underrun)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_v0 = 1'b0; m_v1 = 1'b0; m_ovr = 1'b0; m_und = 1'b0;
    m_b0 = 8'hAA; m_b1 = 8'hEE;
    exp_q.delete();
  endtask

  task automatic chk_all(input string tag);
    logic e_full, e_avail, e_zero;
    logic [7:0] e_data;
    case ({one_byte_mode, m_v0, m_v1})
      3'b000: begin e_full = 0; e_avail = 0; e_zero = 1; end
      3'b010: begin e_full = 0; e_avail = 0; e_zero = 0; end
      3'b011: begin e_full = 1; e_avail = 1; e_zero = 0; end
      3'b001: begin e_full = 1; e_avail = 1; e_zero = 0; end
      3'b100: begin e_full = 0; e_avail = 0; e_zero = 1; end
      3'b101: begin e_full = 0; e_avail = 1; e_zero = 1; end
      default: begin e_full = 1; e_avail = 1; e_zero = 0; end
    endcase
    e_data = m_v0 ? m_b0 : m_b1;
    chk({tag, ".p_data"}, p_data, e_data);
    chk({tag, ".avail"}, {7'd0, p_data_available}, {7'd0, e_avail});
    chk({tag, ".zero"}, {7'd0, p_zero_bytes_available}, {7'd0, e_zero});
    chk({tag, ".full"}, {7'd0, h_full}, {7'd0, e_full});
    chk({tag, ".ovr"}, {7'd0, h_overrun}, {7'd0, m_ovr});
    chk({tag, ".und"}, {7'd0, p_underrun}, {7'd0, m_und});
  endtask

  // One clock of stimulus: drive strobes, check read data before the edge, update model after.
  task automatic step(input string tag, input logic wr, input logic [7:0] d, input logic rd);
    logic nv0, nv1, full_pre, took;
    logic [7:0] nb0, nb1;
    h_wr_stb = wr; h_data = d; p_rd_stb = rd;
    nv0 = m_v0; nv1 = m_v1; nb0 = m_b0; nb1 = m_b1;
    full_pre = one_byte_mode ? m_v0 : m_v1;
    took = 1'b0;
    m_und = 1'b0;
    if (rd) begin
      if (m_v0) begin nv0 = 1'b0; took = 1'b1; end
      else if (!one_byte_mode && m_v1) begin nv1 = 1'b0; took = 1'b1; end
      else m_und = 1'b1;
    end
    if (took && exp_q.size() > 0) chk({tag, ".rd_byte"}, p_data, exp_q.pop_front());
    m_ovr = wr & full_pre;
    if (wr && !full_pre) begin
      if (one_byte_mode || !m_v0) begin nb0 = d; nv0 = 1'b1; end
      else begin nb1 = d; nv1 = 1'b1; end
      exp_q.push_back(d);
    end
    @(posedge clk);
    #1;
    m_v0 = nv0; m_v1 = nv1; m_b0 = nb0; m_b1 = nb1;
    h_wr_stb = 1'b0; p_rd_stb = 1'b0;
    chk_all(tag);
  endtask

  // Asynchronous reset pulse between edges; checked before any clock edge follows.
  task automatic async_reset(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    chk_all(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; h_wr_stb = 1'b0; h_data = 8'h00; p_rd_stb = 1'b0; one_byte_mode = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    chk("reset.p_data_const", p_data, 8'hEE);
    rst = 1'b0;

    // two-byte group transfer
    step("w2_first", 1'b1, 8'h12, 1'b0);
    chk("w2_first.avail_low", {7'd0, p_data_available}, 8'd0);
    step("w2_second", 1'b1, 8'h34, 1'b0);
    chk("w2_second.avail_high", {7'd0, p_data_available}, 8'd1);
    chk("w2_rd0.byte", p_data, 8'h12);
    step("w2_rd0", 1'b0, 8'h00, 1'b1);
    chk("w2_rd0.full_held", {7'd0, h_full}, 8'd1);
    chk("w2_rd1.byte", p_data, 8'h34);
    step("w2_rd1", 1'b0, 8'h00, 1'b1);
    chk("w2_rd1.full_low", {7'd0, h_full}, 8'd0);

    // reset mid-fill discards the held byte
    step("midfill", 1'b1, 8'h55, 1'b0);
    async_reset("midfill_rst");

    // one-byte latch mode with overrun
    one_byte_mode = 1'b1;
    step("w1_first", 1'b1, 8'h5A, 1'b0);
    step("w1_ovr", 1'b1, 8'hC3, 1'b0);
    chk("w1_ovr.pulse", {7'd0, h_overrun}, 8'd1);
    step("w1_idle", 1'b0, 8'h00, 1'b0);
    chk("w1_rd.byte", p_data, 8'h5A);
    step("w1_rd", 1'b0, 8'h00, 1'b1);

    // underrun in both modes, back-to-back
    step("und1_a", 1'b0, 8'h00, 1'b1);
    step("und1_b", 1'b0, 8'h00, 1'b1);
    step("und1_idle", 1'b0, 8'h00, 1'b0);
    one_byte_mode = 1'b0;
    step("und2", 1'b0, 8'h00, 1'b1);
    step("und2_idle", 1'b0, 8'h00, 1'b0);

    // simultaneous write and read with v0 held
    step("sim_fill", 1'b1, 8'h11, 1'b0);
    step("sim_wr_rd", 1'b1, 8'h77, 1'b1);
    chk("sim.p_data", p_data, 8'h77);
    chk("sim.full", {7'd0, h_full}, 8'd1);
    step("sim_drain", 1'b0, 8'h00, 1'b1);

    // one-byte mode simultaneous: write dropped, read clears
    one_byte_mode = 1'b1;
    step("sim1_fill", 1'b1, 8'h3C, 1'b0);
    step("sim1_wr_rd", 1'b1, 8'h99, 1'b1);
    step("sim1_idle", 1'b0, 8'h00, 1'b0);

    // random strobes, two-byte mode then one-byte mode
    async_reset("rnd2_rst");
    one_byte_mode = 1'b0;
    for (int i = 0; i < 300; i++)
      step("rnd2", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    async_reset("rnd1_rst");
    one_byte_mode = 1'b1;
    for (int i = 0; i < 300; i++)
      step("rnd1", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
